// File: rtl/pc_seq_ras_if.sv
// Control/status bundle between the CPU state controller (master) and the
// program-address sequencer (slave).
interface pc_seq_ras_if #(
    parameter int ADDR_W = 13
);
    logic              stall;
    logic              load;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] tgt_addr;
    logic [ADDR_W-1:0] pc_addr;
    logic              ras_empty;
    logic              ras_full;
    logic              ras_ovf;
    logic              ras_unf;

    modport master (
        output stall, load, call, ret, tgt_addr,
        input  pc_addr, ras_empty, ras_full, ras_ovf, ras_unf
    );

    modport slave (
        input  stall, load, call, ret, tgt_addr,
        output pc_addr, ras_empty, ras_full, ras_ovf, ras_unf
    );
endinterface

// File: rtl/pc_seq_ras.sv
// Program-address sequencer with stall, jump, call and return, backed by a
// circular return-address stack that overwrites its oldest entry when full.
module pc_seq_ras #(
    parameter int                ADDR_W     = 13,
    parameter int                STEP       = 1,
    parameter int                RAS_DEPTH  = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic         clk,
    input  logic         rst,
    pc_seq_ras_if.slave  bus
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic              ras_we;
    logic [PTR_W-1:0]  ras_wa;
    logic [ADDR_W-1:0] pc_inc;

    // Return addresses wrap modulo 2^ADDR_W exactly like sequential advance.
    assign pc_inc = pc_q + ADDR_W'(STEP);

    // NOTE: every variable gets a default at the top of the block so no path
    // can leave one unassigned and infer a latch.
    always_comb begin
        pc_d   = pc_q;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        ras_we = 1'b0;
        ras_wa = ptr_q;

        if (bus.stall) begin
            pc_d = pc_q;
        end else if (bus.call && bus.ret) begin
            // Exchange: tail-call style, replace top in place, depth unchanged.
            pc_d   = bus.tgt_addr;
            ras_we = 1'b1;
            ras_wa = ptr_q;
        end else if (bus.ret) begin
            if (cnt_q != '0) begin
                pc_d  = ras_q[ptr_q];
                ptr_d = ptr_q - PTR_W'(1);
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                pc_d  = pc_inc;
                unf_d = 1'b1;
            end
        end else if (bus.call) begin
            pc_d   = bus.tgt_addr;
            ptr_d  = ptr_q + PTR_W'(1);
            ras_we = 1'b1;
            ras_wa = ptr_q + PTR_W'(1);
            if (cnt_q == CNT_FULL) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (bus.load) begin
            pc_d = bus.tgt_addr;
        end else begin
            pc_d = pc_inc;
        end

        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == CNT_FULL);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_ADDR;
            ptr_q   <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // NOTE: the stack storage is deliberately not reset; count gates every
    // read, so stale contents are never observed and the array stays plain RAM.
    always_ff @(posedge clk) begin
        if (ras_we && !rst) begin
            ras_q[ras_wa] <= pc_inc;
        end
    end

    assign bus.pc_addr   = pc_q;
    assign bus.ras_empty = empty_q;
    assign bus.ras_full  = full_q;
    assign bus.ras_ovf   = ovf_q;
    assign bus.ras_unf   = unf_q;
endmodule

// File: tb/tb_pc_seq_ras.sv
// Directed bench for pc_seq_ras: default instance plus a 16-bit/STEP=2 instance.
module tb_pc_seq_ras;
    logic clk;
    logic rst;
    logic rst_b;
    int   checks;
    int   failures;

    pc_seq_ras_if #(.ADDR_W(13)) bus_a ();
    pc_seq_ras_if #(.ADDR_W(16)) bus_b ();

    pc_seq_ras #(
        .ADDR_W(13), .STEP(1), .RAS_DEPTH(4), .RESET_ADDR(13'h0000)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );

    pc_seq_ras #(
        .ADDR_W(16), .STEP(2), .RAS_DEPTH(4), .RESET_ADDR(16'h8000)
    ) dut_b (
        .clk(clk), .rst(rst_b), .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic s, input logic l, input logic c, input logic r,
                           input logic [12:0] t);
        bus_a.stall    = s;
        bus_a.load     = l;
        bus_a.call     = c;
        bus_a.ret      = r;
        bus_a.tgt_addr = t;
    endtask

    task automatic idle_a();
        drive_a(1'b0, 1'b0, 1'b0, 1'b0, 13'h0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        rst_b    = 1'b1;
        idle_a();
        bus_b.stall = 1'b0; bus_b.load = 1'b0; bus_b.call = 1'b0;
        bus_b.ret   = 1'b0; bus_b.tgt_addr = 16'h0;

        // Reset state
        step(); step();
        check("rst_pc",    bus_a.pc_addr,   32'h0);
        check("rst_empty", bus_a.ras_empty, 32'h1);
        check("rst_full",  bus_a.ras_full,  32'h0);
        check("rst_ovf",   bus_a.ras_ovf,   32'h0);
        check("rst_unf",   bus_a.ras_unf,   32'h0);
        rst = 1'b0;
        step();
        check("first_inc", bus_a.pc_addr, 32'h1);

        // Asynchronous reset mid-run
        drive_a(1'b0, 1'b1, 1'b0, 1'b0, 13'h0123);
        step();
        check("load_123", bus_a.pc_addr, 32'h123);
        idle_a();
        #3 rst = 1'b1;
        #1 check("async_rst_pc", bus_a.pc_addr, 32'h0);
        step();
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("seq_%0d", i), bus_a.pc_addr, 32'(i));
        end

        // Wrap at 2^13
        drive_a(1'b0, 1'b1, 1'b0, 1'b0, 13'h1FFE);
        step(); check("wrap_load", bus_a.pc_addr, 32'h1FFE);
        idle_a();
        step(); check("wrap_1fff", bus_a.pc_addr, 32'h1FFF);
        step(); check("wrap_0",    bus_a.pc_addr, 32'h0);
        check("wrap_ovf", bus_a.ras_ovf, 32'h0);
        check("wrap_unf", bus_a.ras_unf, 32'h0);

        // Nested call/return
        drive_a(1'b0, 1'b1, 1'b0, 1'b0, 13'h0010);
        step(); check("nest_at10", bus_a.pc_addr, 32'h10);
        drive_a(1'b0, 1'b0, 1'b1, 1'b0, 13'h0100);
        step(); check("nest_c1", bus_a.pc_addr, 32'h100); check("nest_e1", bus_a.ras_empty, 32'h0);
        idle_a();
        step(); check("nest_101", bus_a.pc_addr, 32'h101);
        drive_a(1'b0, 1'b0, 1'b1, 1'b0, 13'h0200);
        step(); check("nest_c2", bus_a.pc_addr, 32'h200); check("nest_e2", bus_a.ras_empty, 32'h0);
        drive_a(1'b0, 1'b0, 1'b0, 1'b1, 13'h0);
        step(); check("nest_r1", bus_a.pc_addr, 32'h102); check("nest_e3", bus_a.ras_empty, 32'h0);
        step(); check("nest_r2", bus_a.pc_addr, 32'h11);  check("nest_e4", bus_a.ras_empty, 32'h1);

        // Overflow: return addrs 0x12, 0x301, 0x401, 0x501, 0x601
        for (int i = 0; i < 5; i++) begin
            drive_a(1'b0, 1'b0, 1'b1, 1'b0, 13'(32'h300 + 32'h100 * i));
            step();
            check($sformatf("ovf_pc_%0d", i), bus_a.pc_addr, 32'h300 + 32'h100 * i);
            check($sformatf("ovf_flag_%0d", i), bus_a.ras_ovf, (i == 4) ? 32'h1 : 32'h0);
            check($sformatf("ovf_full_%0d", i), bus_a.ras_full, (i >= 3) ? 32'h1 : 32'h0);
        end
        drive_a(1'b0, 1'b0, 1'b0, 1'b1, 13'h0);
        step(); check("pop_a5", bus_a.pc_addr, 32'h601); check("ovf_clr", bus_a.ras_ovf, 32'h0);
        check("pop_a5_full", bus_a.ras_full, 32'h0);
        step(); check("pop_a4", bus_a.pc_addr, 32'h501);
        step(); check("pop_a3", bus_a.pc_addr, 32'h401);
        step(); check("pop_a2", bus_a.pc_addr, 32'h301); check("pop_empty", bus_a.ras_empty, 32'h1);
        step(); check("unf_pc", bus_a.pc_addr, 32'h302); check("unf_flag", bus_a.ras_unf, 32'h1);
        idle_a();
        step(); check("unf_clr", bus_a.ras_unf, 32'h0); check("unf_next", bus_a.pc_addr, 32'h303);

        // Build count=2 at pc=0x40: return entries 0x31, 0x36
        drive_a(1'b0, 1'b1, 1'b0, 1'b0, 13'h0030); step();
        drive_a(1'b0, 1'b0, 1'b1, 1'b0, 13'h0035); step();
        drive_a(1'b0, 1'b0, 1'b1, 1'b0, 13'h003F); step();
        idle_a();
        step(); check("pre_stall_pc", bus_a.pc_addr, 32'h40);

        // Stall overrides call
        drive_a(1'b1, 1'b0, 1'b1, 1'b0, 13'h0999);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall_pc_%0d", i), bus_a.pc_addr, 32'h40);
            check($sformatf("stall_ovf_%0d", i), bus_a.ras_ovf, 32'h0);
            check($sformatf("stall_empty_%0d", i), bus_a.ras_empty, 32'h0);
        end

        // call+ret exchange, then load+ret (ret wins)
        drive_a(1'b0, 1'b0, 1'b1, 1'b1, 13'h0080);
        step(); check("xchg_pc", bus_a.pc_addr, 32'h80);
        check("xchg_empty", bus_a.ras_empty, 32'h0); check("xchg_full", bus_a.ras_full, 32'h0);
        drive_a(1'b0, 1'b1, 1'b0, 1'b1, 13'h0555);
        step(); check("ldret_pc", bus_a.pc_addr, 32'h41); check("ldret_empty", bus_a.ras_empty, 32'h0);
        drive_a(1'b0, 1'b0, 1'b0, 1'b1, 13'h0);
        step(); check("xchg_bottom", bus_a.pc_addr, 32'h31); check("xchg_drained", bus_a.ras_empty, 32'h1);
        idle_a();

        // Parameter sweep instance
        check("b_rst_pc", bus_b.pc_addr, 32'h8000);
        rst_b = 1'b0;
        step(); check("b_inc1", bus_b.pc_addr, 32'h8002);
        step(); check("b_inc2", bus_b.pc_addr, 32'h8004);
        bus_b.call = 1'b1; bus_b.tgt_addr = 16'h1234;
        step(); check("b_call", bus_b.pc_addr, 32'h1234);
        bus_b.call = 1'b0; bus_b.ret = 1'b1;
        step(); check("b_ret", bus_b.pc_addr, 32'h8006);
        bus_b.ret = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_seq_ras.md
Name: pc_seq_ras

Overview:
- Parametrised program-address sequencer; next generation of the CPU's program counter.
- Supplies the instruction-ROM fetch address each cycle and supports stall, absolute jump, call and return.
- Call/return use an internal circular return-address stack (RAS).
- Sits between the CPU state controller, which drives the control strobes, and the instruction memory address port.

Parameters:
ADDR_W, 13, width of the program address in bits
STEP, 1, increment applied on sequential advance (1 = one word per instruction)
RAS_DEPTH, 4, number of return-address stack entries; power of two, minimum 2
RESET_ADDR, 0, pc_addr value loaded on reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
stall  in  1  hold; freezes pc and RAS, overrides every other strobe
load  in  1  absolute jump to tgt_addr
call  in  1  jump to tgt_addr and push return address
ret  in  1  pop RAS top into pc
tgt_addr  in  ADDR_W  jump/call target
pc_addr  out  ADDR_W  current fetch address, registered
ras_empty  out  1  RAS holds 0 valid entries
ras_full  out  1  RAS holds RAS_DEPTH valid entries
ras_ovf  out  1  one-cycle pulse: call overwrote the oldest entry
ras_unf  out  1  one-cycle pulse: ret issued with the RAS empty

Behaviour:
- Clock and reset: reset rst, asynchronous, active-high; clock clk.
- Reset values: pc_addr=RESET_ADDR, RAS count=0, ras_empty=1, ras_full=0, ras_ovf=0, ras_unf=0. Stack contents are don't-care.
- Reset asserted mid-operation aborts any pending action. The first edge after rst deasserts applies normal next-state from RESET_ADDR.
- Latency: all outputs are registered. A strobe sampled at edge N is visible on pc_addr after edge N.
- Next-state priority per edge, highest first:
  1. stall=1: no change to pc, RAS or count. ras_ovf and ras_unf drive 0. All other strobes are ignored.
  2. call=1 and ret=1 together: pc<=tgt_addr. The top entry is replaced with pc_addr+STEP. Count and flags are unchanged (exchange).
  3. ret=1: if count>0, pc<=top entry and count decrements. If count=0, pc<=pc_addr+STEP, count stays 0, ras_unf=1 for one cycle.
  4. call=1: push pc_addr+STEP and pc<=tgt_addr. If count=RAS_DEPTH, the write pointer wraps and overwrites the oldest entry, count stays RAS_DEPTH, ras_ovf=1 for one cycle.
  5. load=1: pc<=tgt_addr. RAS untouched.
  6. Otherwise: pc<=pc_addr+STEP.
- load combined with call or ret: load is ignored.
- Arithmetic: pc_addr+STEP truncates to ADDR_W bits. 2^ADDR_W-1 with STEP=1 wraps to 0 with no flag. Pushed return addresses wrap identically.
- RAS implementation: circular buffer with top pointer (log2 RAS_DEPTH bits) and count (0..RAS_DEPTH).
  - Push: pointer+1 mod RAS_DEPTH.
  - Pop: reads the entry at pointer, then pointer-1 mod RAS_DEPTH.
  - After an overflow, the most recent RAS_DEPTH return addresses pop correctly in LIFO order.
- Flag decode: ras_empty=(count==0), ras_full=(count==RAS_DEPTH), both registered and updated in the same edge as count.

Test Plan:
- Reset and sequence: assert rst mid-run at pc=0x0123 -> pc_addr=0 immediately (asynchronous); release, 5 idle clocks -> 1,2,3,4,5.
- Wrap: load tgt=0x1FFE, 2 idle clocks (ADDR_W=13) -> 0x1FFE, 0x1FFF, 0x0000; no flags.
- Nested call/return: at pc=0x10 call 0x100; at 0x101 call 0x200; ret; ret -> pc sequence 0x100, 0x101, 0x200, 0x102, 0x11; ras_empty 1→0→0→0→1.
- Overflow: 5 calls with DEPTH=4 from return addrs A1..A5 -> ras_ovf pulses on call 5 only; 4 rets return A5, A4, A3, A2; 5th ret -> ras_unf pulse, pc=prev+1.
- Stall/priority: stall=1 with call=1 for 3 clocks -> pc and count frozen, no flags. Then call+ret at pc=0x40, tgt=0x80, count=2 -> pc=0x80, count=2, top=0x41. load+ret -> ret wins.
- Parameter sweep: ADDR_W=16, STEP=2, RESET_ADDR=0x8000 -> reset 0x8000, then 0x8002, 0x8004; call at 0x8004 pushes 0x8006.
